// File: rtl/fetch_unit.sv
// PC register and instruction-fetch stage of the RV32I pipeline: single-outstanding
// imem requests, IF/ID register fill, stall buffering, redirect kill and misalign trap.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic             i_stall,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_gnt,
    input  logic             i_imem_rvalid,
    input  logic [WIDTH-1:0] i_imem_rdata,
    output logic             o_ifid_valid,
    output logic [WIDTH-1:0] o_ifid_instr,
    output logic [WIDTH-1:0] o_ifid_pc,
    output logic [WIDTH-1:0] o_ifid_pc4,
    output logic             o_misalign
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [1:0]       state, state_d;
    logic [WIDTH-1:0] pc, pc_d, pc_plus4;
    logic             kill, kill_d;
    logic [WIDTH-1:0] hold_buf, hold_buf_d;
    logic             ifid_valid_d;
    logic [WIDTH-1:0] ifid_instr_d, ifid_pc_d, ifid_pc4_d;
    logic             misalign_d;
    logic             resp_pending;
    logic             target_misaligned;

    assign pc_plus4          = pc + PC_STEP;
    assign target_misaligned = (i_redirect_pc[1:0] != 2'b00);

    // Request is a pure decode of the state register, masked while reset is held.
    assign o_imem_req  = i_rst_n && (state == S_FETCH);
    assign o_imem_addr = pc;

    // Next-state, PC and IF/ID update logic.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        kill_d       = kill;
        hold_buf_d   = hold_buf;
        ifid_valid_d = i_stall ? o_ifid_valid : 1'b0;
        ifid_instr_d = o_ifid_instr;
        ifid_pc_d    = o_ifid_pc;
        ifid_pc4_d   = o_ifid_pc4;
        misalign_d   = 1'b0;
        resp_pending = 1'b0;

        case (state)
            S_FETCH: begin
                if (i_imem_rvalid && kill) begin
                    kill_d = 1'b0;
                end
                if (i_imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (kill) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else if (!i_stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = i_imem_rdata;
                        ifid_pc_d    = pc;
                        ifid_pc4_d   = pc_plus4;
                        pc_d         = pc_plus4;
                        state_d      = S_FETCH;
                    end else begin
                        hold_buf_d = i_imem_rdata;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_instr_d = hold_buf;
                    ifid_pc_d    = pc;
                    ifid_pc4_d   = pc_plus4;
                    pc_d         = pc_plus4;
                    state_d      = S_FETCH;
                end
            end
            default: begin
                if (i_imem_rvalid && kill) begin
                    kill_d = 1'b0;
                end
            end
        endcase

        // Redirect overrides everything; an accepted-but-unanswered request must be killed.
        if (i_redirect) begin
            case (state)
                S_FETCH: resp_pending = i_imem_gnt;
                S_WAIT:  resp_pending = !i_imem_rvalid;
                default: resp_pending = 1'b0;
            endcase
            pc_d         = i_redirect_pc;
            ifid_valid_d = 1'b0;
            kill_d       = resp_pending || (kill && !i_imem_rvalid && (state != S_WAIT));
            misalign_d   = target_misaligned;
            if (target_misaligned) begin
                state_d = S_ERR;
            end else if (resp_pending) begin
                state_d = S_WAIT;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            hold_buf     <= '0;
            o_ifid_valid <= 1'b0;
            o_ifid_instr <= '0;
            o_ifid_pc    <= '0;
            o_ifid_pc4   <= '0;
            o_misalign   <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            kill         <= kill_d;
            hold_buf     <= hold_buf_d;
            o_ifid_valid <= ifid_valid_d;
            o_ifid_instr <= ifid_instr_d;
            o_ifid_pc    <= ifid_pc_d;
            o_ifid_pc4   <= ifid_pc4_d;
            o_misalign   <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem responder plus a scoreboard of
// instructions expected to reach IF/ID.
module tb_fetch_unit;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];
    exp_t last_exp;
    int   deliveries = 0;
    bit   last_valid = 0;

    // Memory responder state
    bit          pending = 0;
    bit          pdrop   = 0;
    int          cnt     = 0;
    int          delay   = 0;
    logic [31:0] paddr   = '0;
    logic [31:0] rv_addr = '0;
    bit          rv_drop = 0;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_stall       (stall),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_ifid_valid  (ifid_valid),
        .o_ifid_instr  (ifid_instr),
        .o_ifid_pc     (ifid_pc),
        .o_ifid_pc4    (ifid_pc4),
        .o_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: the inputs set now are seen by the next rising edge; outputs sampled on the falling edge.
    task automatic step();
        bit          hs, r_redir, r_stall, r_rv, r_rv_drop, fresh;
        logic [31:0] hs_addr, r_rv_addr;
        exp_t        e;
        hs        = imem_req && imem_gnt;
        hs_addr   = imem_addr;
        r_redir   = redirect;
        r_stall   = stall;
        r_rv      = imem_rvalid;
        r_rv_drop = rv_drop;
        r_rv_addr = rv_addr;
        @(negedge clk);
        if (r_rv && !r_rv_drop && !r_redir) begin
            e.instr = r_rv_addr ^ PAT;
            e.pc    = r_rv_addr;
            e.pc4   = r_rv_addr + 32'd4;
            sb.push_back(e);
        end
        imem_rvalid = 1'b0;
        if (pending && r_redir) pdrop = 1;
        if (hs) begin
            pending = 1;
            paddr   = hs_addr;
            cnt     = delay;
            pdrop   = r_redir;
        end
        if (pending) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ PAT;
                rv_addr     = paddr;
                rv_drop     = pdrop;
                pending     = 0;
            end else begin
                cnt--;
            end
        end
        fresh = ifid_valid && !(last_valid && r_stall);
        if (fresh) begin
            deliveries++;
            if (sb.size() == 0) begin
                check("unexpected_delivery_pc", ifid_pc, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                check("ifid_instr", ifid_instr, e.instr);
                check("ifid_pc", ifid_pc, e.pc);
                check("ifid_pc4", ifid_pc4, e.pc4);
            end
        end
        last_valid = ifid_valid;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(imem_req), 32'd1);
    endtask

    initial begin
        int d0;
        int req_cycles;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Reset values
        #12;
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_instr", ifid_instr, 32'd0);
        check("rst_pc", ifid_pc, 32'd0);
        check("rst_pc4", ifid_pc4, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'd0);

        // Streaming: one instruction every 2 cycles
        d0 = deliveries;
        steps(8);
        check("stream_count", 32'(deliveries - d0), 32'd4);
        check("stream_last_pc", ifid_pc, 32'd12);

        // Stall while a response arrives: IF/ID frozen, buffered instr delivered on release
        stall = 1'b1;
        steps(5);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(ifid_valid), 32'd1);
        check("stall_pc", ifid_pc, last_exp.pc);
        check("stall_instr", ifid_instr, last_exp.instr);
        d0 = deliveries;
        stall = 1'b0;
        step();
        check("release_count", 32'(deliveries - d0), 32'd1);
        check("release_pc", ifid_pc, 32'd16);
        check("resume_addr", imem_addr, 32'd20);

        // Redirect in WAIT, stale response 3 cycles later
        delay = 3;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        delay    = 0;
        check("redir_wait_req", 32'(imem_req), 32'd0);
        check("redir_wait_valid", 32'(ifid_valid), 32'd0);
        wait_req("redir_wait_refetch");
        check("redir_wait_addr", imem_addr, 32'h100);
        steps(4);
        check("redir_wait_stream", ifid_pc, 32'h104);

        // Redirect in the same cycle as gnt
        wait_req("redir_gnt_pre");
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("redir_gnt_req", 32'(imem_req), 32'd0);
        wait_req("redir_gnt_refetch");
        check("redir_gnt_addr", imem_addr, 32'h200);
        steps(4);
        check("redir_gnt_stream", ifid_pc, 32'h204);

        // Misaligned target: one-cycle pulse, idle until the next redirect
        wait_req("mis_pre");
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_valid", 32'(ifid_valid), 32'd0);
        step();
        check("mis_pulse_end", 32'(misalign), 32'd0);
        req_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req) req_cycles++;
            step();
        end
        check("mis_idle_reqs", 32'(req_cycles), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        check("mis_recover_req", 32'(imem_req), 32'd1);
        check("mis_recover_addr", imem_addr, 32'h300);
        steps(4);
        check("mis_recover_stream", ifid_pc, 32'h304);

        // Async reset while a response is outstanding
        wait_req("arst_pre");
        delay = 3;
        step();
        imem_gnt = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ifid_valid), 32'd0);
        check("arst_pc", ifid_pc, 32'd0);
        check("arst_instr", ifid_instr, 32'd0);
        check("arst_req", 32'(imem_req), 32'd0);
        pdrop      = 1;
        last_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        delay = 0;
        #1;
        check("arst_first_req", 32'(imem_req), 32'd1);
        check("arst_first_addr", imem_addr, 32'd0);
        steps(4);
        check("arst_late_req", 32'(imem_req), 32'd1);
        check("arst_late_addr", imem_addr, 32'd0);
        check("arst_late_valid", 32'(ifid_valid), 32'd0);
        imem_gnt = 1'b1;
        steps(4);
        check("arst_stream", ifid_pc, 32'd4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
